button_debouncer: RTL and testbench

Conditions the raw push-button input of the safe design before it reaches `pushed_button_duration`. It synchronizes the asynchronous button into `clk` and filters contact bounce with a stability counter. It outputs a clean level plus single-cycle press and release strobes. Its `button_level` drives the `signal_input` of `pushed_button_duration`, which then classifies short and long pushes for `safe`.

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/button_debouncer_sync_2ff.sv | 27 ++
 rtl/button_debouncer.sv | 108 ++++++++++
 tb/tb_button_debouncer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CLK_FREQ_HZ             = 50000000;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// One-bit two-flop synchronizer with a selectable reset value.
// Reusable for any slow asynchronous switch input.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, stability counter, level and press/release strobes.
// Define BUTTON_DEBOUNCER_ACTIVE_LOW_EN for active-low key pads.
//
// state      | meaning
// IDLE_LOW   | accepted level 0, waiting for a 1 sample
// CHECK_HIGH | counting consecutive 1 samples
// IDLE_HIGH  | accepted level 1, waiting for a 0 sample
// CHECK_LOW  | counting consecutive 0 samples
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic async_reset,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic            sync_q;
  logic            btn;
  debounce_state_t state;
  logic [CNT_WIDTH-1:0] cnt;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
  // Synchronizer holds the raw pad level, so resetting it to 1 means "released";
  // inversion after it keeps the logical value 0 through and after reset.
  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (async_reset),
    .d     (button_raw),
    .q     (sync_q)
  );
  assign btn = ~sync_q;
`else
  sync_2ff #(.RESET_VALUE(1'b0)) u_sync (
    .clk   (clk),
    .reset (async_reset),
    .d     (button_raw),
    .q     (sync_q)
  );
  assign btn = sync_q;
`endif

  always_ff @(posedge clk) begin
    if (async_reset) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (btn) begin
            state <= CHECK_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_HIGH: begin
          if (!btn) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE_HIGH;
            cnt          <= '0;
            button_level <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!btn) begin
            state <= CHECK_LOW;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_LOW: begin
          if (btn) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE_LOW;
            cnt           <= '0;
            button_level  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic async_reset;
  logic button_raw;
  logic button_level;
  logic press_pulse;
  logic release_pulse;

  button_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk           (clk),
    .async_reset   (async_reset),
    .button_raw    (button_raw),
    .button_level  (button_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic raw;
    logic lvl;
    logic prs;
    logic rel;
  } vec_t;

  typedef struct packed {
    logic lvl;
    logic prs;
    logic rel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Table entries use the logical button value; map to the pad level here.
  function automatic logic pad(input logic lvl);
`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
    return ~lvl;
`else
    return lvl;
`endif
  endfunction

  task automatic add(input logic rst, input logic raw, input logic lvl,
                     input logic prs, input logic rel, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, raw, lvl, prs, rel});
  endtask

  task automatic step(input string name, input logic rst, input logic raw,
                      input logic lvl, input logic prs, input logic rel);
    exp_t e;
    exp_t a;
    @(negedge clk);
    async_reset = rst;
    button_raw  = pad(raw);
    sb_q.push_back('{lvl, prs, rel});
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    a = '{button_level, press_pulse, release_pulse};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: level/press/release got %b required %b", name, cyc, a, e);
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    async_reset = 1'b1;
    button_raw  = pad(1'b0);

    // reset with button released: level must stay 0
    add(1, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 4);
    // reset with button held: level rises at the 6th edge after deassert
    add(1, 1, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 5);
    add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 2);
    // release
    add(0, 0, 1, 0, 0, 5);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 2);
    // clean press
    add(0, 1, 0, 0, 0, 5);
    add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 2);
    // release back to idle low
    add(0, 0, 1, 0, 0, 5);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 3);

    foreach (vecs[i])
      step("table", vecs[i].rst, vecs[i].raw, vecs[i].lvl, vecs[i].prs, vecs[i].rel);

    // bounce: raw 1,1,1,0,1,1,1,1,1,0 then held 0 (bit 0 applied first)
    pat = 10'b0111110111;
    for (int k = 1; k <= 16; k++) begin
      step("bounce",
           1'b0,
           (k <= 10) ? pat[k-1] : 1'b0,
           (k >= 10 && k < 15),
           (k == 10),
           (k == 15));
    end
    step("bounce_idle", 0, 0, 0, 0, 0);

    // reset on the third qualification edge of a press
    for (int k = 1; k <= 4; k++) step("mid_reset_count", 0, 1, 0, 0, 0);
    step("mid_reset_edge", 1, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step("mid_reset_after", 0, 0, 0, 0, 0);
    // full latency after reset proves the count was discarded
    for (int k = 1; k <= 5; k++) step("post_reset_press", 0, 1, 0, 0, 0);
    step("post_reset_accept", 0, 1, 1, 1, 0);
    step("post_reset_hold", 0, 1, 1, 0, 0);
    step("post_reset_hold", 0, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
